// File: rtl/unsigned_serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one bit per clock, LSB first.
// Result, borrow and zero flag are held after DONE until the next accepted start.
module unsigned_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             d_bit;
    logic             accept;
    logic             last_bit;

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign d_bit     = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign diff_next = {d_bit, diff_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch can form.
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                accept     = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // start during RUN falls through here untouched: not accepted, not queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            diff_sh    <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else if (accept) begin
            a_sh       <= a;
            b_sh       <= b;
            diff_sh    <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else if (state == RUN) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            diff_sh <= diff_next;
            cnt     <= cnt + 1'b1;
            br      <= br_next;
            if (last_bit) begin
                borrow_out <= br_next;
                zero       <= (diff_next == '0);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign diff = diff_sh;

endmodule

// File: tb/tb_unsigned_serial_subtractor.sv
// Scoreboard bench for unsigned_serial_subtractor at WIDTH=4: expected results
// are queued when operands are driven and popped when done is observed.
module tb_unsigned_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         zero;

    unsigned_serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff),
        .borrow_out(borrow_out), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   r;
        r        = int'(x) - int'(y);
        e.diff   = r[W-1:0];
        e.borrow = (x < y);
        e.zero   = (r[W-1:0] == 0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y);
        a = x;
        b = y;
        sb.push_back(model(x, y));
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) tick();
        total++;
        if ({busy, done, diff, borrow_out, zero} !== '0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%b bo=%b z=%b, want all 0",
                     busy, done, diff, borrow_out, zero);
        end
        start = 1'b1; a = 4'd5; b = 4'd3;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_beats_start: got busy=%b done=%b, want 0 0", busy, done);
        end
        rst = 1'b0; start = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] xs[5] = '{4'b0101, 4'b0110, 4'b1111, 4'b0110, 4'b0000};
        logic [W-1:0] ys[5] = '{4'b0110, 4'b1111, 4'b0110, 4'b0110, 4'b1111};
        exp_t e;
        bit   ok;
        bit   busy_ok;
        for (int v = 0; v < 5; v++) begin
            drive_op(xs[v], ys[v]);
            start = 1'b1;
            tick();
            start = 1'b0;
            busy_ok = 1'b1;
            for (int k = 0; k < W; k++) begin
                if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
                tick();
            end
            total++;
            if (!busy_ok) begin
                bad++;
                $display("FAIL basic_busy[%0d]: busy not high for %0d cycles before done", v, W);
            end
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got done=%b busy=%b, want 1 0", v, done, busy);
            end
            wait_done(ok);
            e = sb.pop_front();
            total++;
            if (!ok || {diff, borrow_out, zero} !== {e.diff, e.borrow, e.zero}) begin
                bad++;
                $display("FAIL basic_result[%0d]: got diff=%b bo=%b z=%b, want diff=%b bo=%b z=%b",
                         v, diff, borrow_out, zero, e.diff, e.borrow, e.zero);
            end
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || diff !== e.diff) begin
                bad++;
                $display("FAIL basic_hold[%0d]: got done=%b busy=%b diff=%b, want 0 0 %b",
                         v, done, busy, diff, e.diff);
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        bit   ok;
        bit   quiet;
        drive_op(4'b1001, 4'b0011);
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 4'b0000; b = 4'b0000;
        tick();
        tick();
        start = 1'b1; a = 4'b1111; b = 4'b0001;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL ignore_busy: got busy=%b, want 1", busy);
        end
        tick();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL ignore_schedule: got done=%b, want 1", done);
        end
        wait_done(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {diff, borrow_out, zero} !== {e.diff, e.borrow, e.zero}) begin
            bad++;
            $display("FAIL ignore_result: got diff=%b bo=%b z=%b, want diff=%b bo=%b z=%b",
                     diff, borrow_out, zero, e.diff, e.borrow, e.zero);
        end
        quiet = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || diff !== e.diff) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL ignore_not_queued: busy=%b done=%b diff=%b, want 0 0 %b",
                     busy, done, diff, e.diff);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        bit   no_done;
        drive_op(4'b1100, 4'b0101);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        total++;
        if ({busy, done, diff, borrow_out, zero} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b diff=%b bo=%b z=%b, want all 0",
                     busy, done, diff, borrow_out, zero);
        end
        no_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
            tick();
        end
        total++;
        if (!no_done) begin
            bad++;
            $display("FAIL reset_mid_no_done: got activity after abort, want none");
        end
        drive_op(4'b0011, 4'b1010);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(ok);
        e = sb.pop_front();
        total++;
        if (!ok || {diff, borrow_out, zero} !== {e.diff, e.borrow, e.zero}) begin
            bad++;
            $display("FAIL reset_mid_fresh: got diff=%b bo=%b z=%b, want diff=%b bo=%b z=%b",
                     diff, borrow_out, zero, e.diff, e.borrow, e.zero);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] xs[$];
        logic [W-1:0] ys[$];
        exp_t e;
        bit   ok;
        int   last_done;
        int   n;
        for (int i = 0; i < 200; i++) begin
            xs.push_back(W'($urandom_range(0, (1 << W) - 1)));
            ys.push_back(W'($urandom_range(0, (1 << W) - 1)));
        end
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                xs.push_back(W'(i));
                ys.push_back(W'(j));
            end
        end
        n = xs.size();
        last_done = 0;
        drive_op(xs[0], ys[0]);
        start = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            wait_done(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL b2b_timeout[%0d]: done never seen", i);
                start = 1'b0;
                return;
            end
            e = sb.pop_front();
            total++;
            if ({diff, borrow_out, zero, busy} !== {e.diff, e.borrow, e.zero, 1'b0}) begin
                bad++;
                $display("FAIL b2b_result[%0d]: a=%b b=%b got diff=%b bo=%b z=%b busy=%b, want diff=%b bo=%b z=%b busy=0",
                         i, xs[i], ys[i], diff, borrow_out, zero, busy, e.diff, e.borrow, e.zero);
            end
            if (i > 0) begin
                total++;
                if (cyc - last_done !== W + 1) begin
                    bad++;
                    $display("FAIL b2b_interval[%0d]: got %0d cycles, want %0d", i, cyc - last_done, W + 1);
                end
            end
            last_done = cyc;
            if (i + 1 < n) drive_op(xs[i+1], ys[i+1]);
            else           start = 1'b0;
            tick();
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
